// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 measurement scheduler:
// FSM states, frame byte offsets and the millisecond prescaler length.
package dht11_pkg;

  typedef enum logic [2:0] {
    SETTLE,
    IDLE,
    START,
    WAIT,
    CHECK,
    UPDATE,
    FAIL
  } state_t;

  localparam int BYTE_W      = 8;
  localparam int FRAME_W     = 40;
  localparam int HUM_INT_LSB = 32;
  localparam int HUM_DEC_LSB = 24;
  localparam int TMP_INT_LSB = 16;
  localparam int TMP_DEC_LSB = 8;
  localparam int CSUM_LSB    = 0;

  // Width of the ms-resolution spacing counters; they saturate rather than wrap.
  localparam int CNT_W = 16;

  function automatic int ms_cycles(input int clk_fre);
    return clk_fre * 1000;
  endfunction

  // Output slot 0 = hum int, 1 = temp dec, 2 = temp int (data_out LSB first).
  function automatic int bcd_src_lsb(input int slot);
    case (slot)
      0:       return HUM_INT_LSB;
      1:       return TMP_DEC_LSB;
      default: return TMP_INT_LSB;
    endcase
  endfunction

  // Sum of the four payload bytes (frame bits [39:8]), modulo 256.
  function automatic logic [BYTE_W-1:0] csum8(input logic [FRAME_W-BYTE_W-1:0] payload);
    return payload[HUM_INT_LSB-BYTE_W +: BYTE_W] + payload[HUM_DEC_LSB-BYTE_W +: BYTE_W]
         + payload[TMP_INT_LSB-BYTE_W +: BYTE_W] + payload[TMP_DEC_LSB-BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// 8-bit binary to two-digit BCD; anything above 99 reads as 99.
module bin2bcd8 (
  input  logic [7:0] i_bin,
  output logic [7:0] o_bcd
);

  logic [3:0] w_tens;
  logic [3:0] w_ones;

  always_comb begin
    w_tens = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (i_bin >= 8'(10 * k)) begin
        w_tens = 4'(k);
      end
    end
    w_ones = 4'(i_bin - 8'(w_tens) * 8'd10);
    o_bcd  = (i_bin > 8'd99) ? 8'h99 : {w_tens, w_ones};
  end

endmodule

// File: rtl/dht11_poll_ctrl.sv
// DHT11 measurement scheduler: periodic and on-demand starts with minimum
// spacing, timeout/retry handling, checksum verification and BCD publishing.
module dht11_poll_ctrl
  import dht11_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int POLL_MS    = 2000,
  parameter int GAP_MS     = 1000,
  parameter int TIMEOUT_MS = 50,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        force_req,
  output logic        meas_start,
  input  logic        meas_done,
  input  logic        meas_err,
  input  logic [39:0] meas_raw,
  output logic [23:0] data_out,
  output logic        data_valid,
  output logic        upd_pulse,
  output logic        sensor_fault,
  output logic [7:0]  fail_cnt
);

  localparam int         MS_CYCLES = ms_cycles(CLK_FRE);
  localparam int         PRE_W     = $clog2(MS_CYCLES + 1);
  localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);

  logic [PRE_W-1:0]   r_pre;
  logic               w_tick;
  logic [CNT_W-1:0]   r_gap;
  logic [CNT_W-1:0]   r_poll;
  logic [CNT_W-1:0]   w_gap_next;
  logic [CNT_W-1:0]   w_poll_next;
  logic               w_gap_ok;
  logic               w_poll_due;
  logic               w_timeout;
  logic               w_csum_ok;

  state_t             r_state;
  logic [7:0]         r_retry;
  logic               r_force_pend;
  logic [FRAME_W-1:0] r_raw;
  logic               r_meas_start;
  logic [23:0]        r_data_out;
  logic               r_data_valid;
  logic               r_upd_pulse;
  logic               r_sensor_fault;
  logic [7:0]         r_fail_cnt;
  logic [23:0]        w_bcd;

  assign w_tick = (r_pre == PRE_W'(MS_CYCLES - 1));

  always_comb begin
    w_gap_next  = r_gap;
    w_poll_next = r_poll;
    if (w_tick && (r_gap != '1)) begin
      w_gap_next = r_gap + CNT_W'(1);
    end
    if (w_tick && (r_poll != '1)) begin
      w_poll_next = r_poll + CNT_W'(1);
    end
  end

  // Start decisions look at the post-edge count, so a start lands on the tick edge itself.
  assign w_gap_ok   = (w_gap_next >= CNT_W'(GAP_MS));
  assign w_poll_due = (w_poll_next >= CNT_W'(POLL_MS));
  assign w_timeout  = (r_gap >= CNT_W'(TIMEOUT_MS));
  assign w_csum_ok  = (csum8(r_raw[FRAME_W-1:BYTE_W]) == r_raw[CSUM_LSB +: BYTE_W]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_gap  <= '0;
      r_poll <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      if (r_state == START) begin
        r_gap  <= '0;
        r_poll <= '0;
      end else begin
        r_gap  <= w_gap_next;
        r_poll <= w_poll_next;
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_bcd
    localparam int SRC_LSB = bcd_src_lsb(gi);
    bin2bcd8 u_bcd (
      .i_bin (r_raw[SRC_LSB +: BYTE_W]),
      .o_bcd (w_bcd[gi*BYTE_W +: BYTE_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= SETTLE;
      r_retry        <= '0;
      r_force_pend   <= 1'b0;
      r_raw          <= '0;
      r_meas_start   <= 1'b0;
      r_data_out     <= '0;
      r_data_valid   <= 1'b0;
      r_upd_pulse    <= 1'b0;
      r_sensor_fault <= 1'b0;
      r_fail_cnt     <= '0;
    end else begin
      r_meas_start <= 1'b0;
      r_upd_pulse  <= 1'b0;
      if (force_req && (r_state != START)) begin
        r_force_pend <= 1'b1;
      end

      case (r_state)
        SETTLE: begin
          if (w_gap_ok) begin
            r_meas_start <= 1'b1;
            r_state      <= START;
          end
        end

        IDLE: begin
          if ((w_poll_due || r_force_pend) && w_gap_ok) begin
            r_meas_start <= 1'b1;
            r_state      <= START;
          end
        end

        START: begin
          r_force_pend <= 1'b0;
          r_state      <= WAIT;
        end

        // Error beats done when both arrive together.
        WAIT: begin
          if (meas_err || w_timeout) begin
            r_state <= FAIL;
          end else if (meas_done) begin
            r_raw   <= meas_raw;
            r_state <= CHECK;
          end
        end

        CHECK: begin
          r_state <= w_csum_ok ? UPDATE : FAIL;
        end

        UPDATE: begin
          r_data_out     <= w_bcd;
          r_upd_pulse    <= 1'b1;
          r_data_valid   <= 1'b1;
          r_retry        <= '0;
          r_sensor_fault <= 1'b0;
          r_state        <= IDLE;
        end

        FAIL: begin
          if (r_fail_cnt != 8'hFF) begin
            r_fail_cnt <= r_fail_cnt + 8'd1;
          end
          if ((r_retry + 8'd1) >= RETRY_LIM) begin
            r_sensor_fault <= 1'b1;
            r_retry        <= '0;
          end else begin
            r_retry      <= r_retry + 8'd1;
            r_force_pend <= 1'b1;
          end
          r_state <= IDLE;
        end

        default: r_state <= SETTLE;
      endcase
    end
  end

  assign meas_start   = r_meas_start;
  assign data_out     = r_data_out;
  assign data_valid   = r_data_valid;
  assign upd_pulse    = r_upd_pulse;
  assign sensor_fault = r_sensor_fault;
  assign fail_cnt     = r_fail_cnt;

endmodule
